// File: rtl/spi_reg_file_pkg.sv
// Shared register map, reset values and SPIE bit positions for the SPI register file.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_reg_file_pkg;

   localparam logic [7:0] ADDR_SPMODE = 8'h00;
   localparam logic [7:0] ADDR_SPIE   = 8'h04;
   localparam logic [7:0] ADDR_SPIM   = 8'h08;
   localparam logic [7:0] ADDR_SPCOM  = 8'h0C;
   localparam logic [7:0] ADDR_SPITF  = 8'h10;
   localparam logic [7:0] ADDR_SPIRF  = 8'h14;

   // EN (bit 31) set out of reset so the FIFOs are usable immediately.
   localparam logic [31:0] SPMODE_DEF = 32'h8070_0400;
   localparam int          SPMODE_EN  = 31;

   localparam int SPIE_DON   = 0;
   localparam int SPIE_RXNE  = 1;
   localparam int SPIE_TXE   = 2;
   localparam int SPIE_TXNF  = 3;
   localparam int SPIE_RXOVF = 4;
   localparam int SPIE_TXOVF = 5;
   localparam int SPIE_RXCNT = 8;
   localparam int SPIE_TXCNT = 16;

   // Count field width: holds 0..16 for the largest supported FIFO depth.
   localparam int CNT_W = 5;

   // The write-one-to-clear event flags of SPIE.
   typedef struct packed {
      logic txovf;
      logic rxovf;
      logic don;
   } spie_w1c_t;

   // Byte-lane merge: lanes with a strobe take new_val, the rest keep old_val.
   function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/spi_reg_file_fifo.sv
// Synchronous word FIFO with flush, used for both TX and RX of the SPI register file.
// Latency: pushed word visible at dout the cycle after the push edge when the FIFO was empty.
// Backpressure: push into a full FIFO is dropped unless a pop happens on the same edge; flush discards push and pop.
module spi_sync_fifo
   import spi_reg_file_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [31:0]      din,
   input  logic             pop,
   input  logic             flush,
   output logic [31:0]      dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      mem_d [DEPTH];
   logic             push_ok, pop_ok;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A pop frees a slot on the same edge, so a full FIFO still accepts a push paired with a pop.
   assign pop_ok  = pop & ~empty & ~flush;
   assign push_ok = push & ~flush & (~full | pop_ok);

   // Pointer, count and storage update; pointers wrap naturally at the power-of-2 depth.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // State register; reset clears contents so nothing stale survives a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/spi_reg_file.sv
// SPI register file: control/status registers, TX/RX word FIFOs and level interrupt for the shift core.
// Latency: writes act on the strobe edge; S_RDATA, irq and cmd_start are registered one cycle later.
// Backpressure: none on register access; TX uses tx_valid/tx_ready, RX overflow drops the word and flags RXOVF.
module spi_reg_file
   import spi_reg_file_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        S_SYSCLK,
   input  logic        S_RESETN,
   input  logic [7:0]  S_AWADDR,
   input  logic [31:0] S_WDATA,
   input  logic [3:0]  S_WSTRB,
   input  logic        S_REG_WEN,
   input  logic [7:0]  S_ARADDR,
   input  logic        S_REG_RDEN,
   output logic [31:0] S_RDATA,
   output logic [31:0] spmode,
   output logic [31:0] spcom,
   output logic        cmd_start,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [31:0] rx_data,
   input  logic        rx_valid,
   input  logic        core_done,
   output logic        irq
);

   logic [31:0]      spmode_q, spmode_d, spim_q, spim_d, spcom_q, spcom_d, rdata_q, rdata_d;
   spie_w1c_t        w1c_q, w1c_d, w1c_clr;
   logic             cmd_start_q, cmd_start_d, irq_q, irq_d;
   logic             wr_spmode, wr_spie, wr_spim, wr_spcom, wr_spitf, rd_spirf, flush;
   logic             tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_ovf;
   logic [CNT_W-1:0] tx_cnt, rx_cnt;
   logic [31:0]      rx_head, spie_rd, rd_mux;

   assign wr_spmode = S_REG_WEN && (S_AWADDR == ADDR_SPMODE);
   assign wr_spie   = S_REG_WEN && (S_AWADDR == ADDR_SPIE);
   assign wr_spim   = S_REG_WEN && (S_AWADDR == ADDR_SPIM);
   assign wr_spcom  = S_REG_WEN && (S_AWADDR == ADDR_SPCOM);
   assign wr_spitf  = S_REG_WEN && (S_AWADDR == ADDR_SPITF);
   assign rd_spirf  = S_REG_RDEN && (S_ARADDR == ADDR_SPIRF);

   // Dropped words: a full FIFO only overflows when no pop frees a slot on the same edge.
   assign tx_ovf = wr_spitf & tx_full & ~tx_ready & ~flush;
   assign rx_ovf = rx_valid & rx_full & ~rd_spirf & ~flush;

   spi_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (S_SYSCLK),
      .rst_n (S_RESETN),
      .push  (wr_spitf),
      .din   (strb_merge(32'h0, S_WDATA, S_WSTRB)),
      .pop   (tx_ready),
      .flush (flush),
      .dout  (tx_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_cnt)
   );

   spi_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (S_SYSCLK),
      .rst_n (S_RESETN),
      .push  (rx_valid),
      .din   (rx_data),
      .pop   (rd_spirf),
      .flush (flush),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_cnt)
   );

   // Byte-masked RW registers; clearing EN flushes both FIFOs on the same edge.
   always_comb begin
      spmode_d    = wr_spmode ? strb_merge(spmode_q, S_WDATA, S_WSTRB) : spmode_q;
      spim_d      = wr_spim   ? strb_merge(spim_q,   S_WDATA, S_WSTRB) : spim_q;
      spcom_d     = wr_spcom  ? strb_merge(spcom_q,  S_WDATA, S_WSTRB) : spcom_q;
      flush       = wr_spmode & spmode_q[SPMODE_EN] & ~spmode_d[SPMODE_EN];
      cmd_start_d = wr_spcom;
   end

   // W1C event flags; every W1C bit sits in byte 0, and a hardware set beats a same-edge clear.
   always_comb begin
      w1c_clr       = '0;
      w1c_clr.don   = wr_spie & S_WSTRB[0] & S_WDATA[SPIE_DON];
      w1c_clr.rxovf = wr_spie & S_WSTRB[0] & S_WDATA[SPIE_RXOVF];
      w1c_clr.txovf = wr_spie & S_WSTRB[0] & S_WDATA[SPIE_TXOVF];
      w1c_d.don     = (w1c_q.don   & ~w1c_clr.don)   | core_done;
      w1c_d.rxovf   = (w1c_q.rxovf & ~w1c_clr.rxovf) | rx_ovf;
      w1c_d.txovf   = (w1c_q.txovf & ~w1c_clr.txovf) | tx_ovf;
   end

   // SPIE read view: live FIFO status merged with the event flags.
   always_comb begin
      spie_rd                       = '0;
      spie_rd[SPIE_DON]             = w1c_q.don;
      spie_rd[SPIE_RXNE]            = ~rx_empty;
      spie_rd[SPIE_TXE]             = tx_empty;
      spie_rd[SPIE_TXNF]            = ~tx_full;
      spie_rd[SPIE_RXOVF]           = w1c_q.rxovf;
      spie_rd[SPIE_TXOVF]           = w1c_q.txovf;
      spie_rd[SPIE_RXCNT +: CNT_W]  = rx_cnt;
      spie_rd[SPIE_TXCNT +: CNT_W]  = tx_cnt;
      irq_d                         = |(spie_rd[5:0] & spim_q[5:0]);
   end

   // Read mux; SPIRF returns the RX head (the FIFO pops it), or 0 when empty.
   always_comb begin
      case (S_ARADDR)
         ADDR_SPMODE: rd_mux = spmode_q;
         ADDR_SPIE:   rd_mux = spie_rd;
         ADDR_SPIM:   rd_mux = spim_q;
         ADDR_SPCOM:  rd_mux = spcom_q;
         ADDR_SPIRF:  rd_mux = rx_empty ? 32'h0 : rx_head;
         default:     rd_mux = 32'h0;
      endcase
      rdata_d = S_REG_RDEN ? rd_mux : rdata_q;
   end

   // Register state; reset drops pending pulses and read data immediately.
   always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
      if (!S_RESETN) begin
         spmode_q    <= SPMODE_DEF;
         spim_q      <= '0;
         spcom_q     <= '0;
         w1c_q       <= '0;
         rdata_q     <= '0;
         cmd_start_q <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         spmode_q    <= spmode_d;
         spim_q      <= spim_d;
         spcom_q     <= spcom_d;
         w1c_q       <= w1c_d;
         rdata_q     <= rdata_d;
         cmd_start_q <= cmd_start_d;
         irq_q       <= irq_d;
      end
   end

   assign S_RDATA   = rdata_q;
   assign spmode    = spmode_q;
   assign spcom     = spcom_q;
   assign cmd_start = cmd_start_q;
   assign irq       = irq_q;
   assign tx_valid  = ~tx_empty;

endmodule

// File: tb/tb_spi_reg_file.sv
// Self-checking bench for spi_reg_file: register table, directed FIFO/IRQ/reset sequences, randomized run vs queue model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: tx_ready and rx_valid are driven by the bench.
module tb_spi_reg_file;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] MODE_DEF = 32'h8070_0400;

   logic        S_SYSCLK, S_RESETN;
   logic [7:0]  S_AWADDR, S_ARADDR;
   logic [31:0] S_WDATA, S_RDATA, spmode, spcom, tx_data, rx_data;
   logic [3:0]  S_WSTRB;
   logic        S_REG_WEN, S_REG_RDEN, cmd_start, tx_valid, tx_ready, rx_valid, core_done, irq;

   int n_checks = 0;
   int n_fail   = 0;

   spi_reg_file #(.FIFO_DEPTH(DEPTH)) dut (
      .S_SYSCLK(S_SYSCLK), .S_RESETN(S_RESETN), .S_AWADDR(S_AWADDR), .S_WDATA(S_WDATA),
      .S_WSTRB(S_WSTRB), .S_REG_WEN(S_REG_WEN), .S_ARADDR(S_ARADDR), .S_REG_RDEN(S_REG_RDEN),
      .S_RDATA(S_RDATA), .spmode(spmode), .spcom(spcom), .cmd_start(cmd_start),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .core_done(core_done), .irq(irq)
   );

   initial begin
      S_SYSCLK = 1'b0;
      forever #5 S_SYSCLK = ~S_SYSCLK;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        wr;
      logic [7:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [7:0]  raddr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   // ---------------- reference model state ----------------
   logic [31:0] m_spmode, m_spim, m_spcom, m_rdata;
   logic        m_don, m_rxovf, m_txovf, m_irq, m_cmd;
   logic [31:0] mtxq[$];
   logic [31:0] mrxq[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge S_SYSCLK);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      S_REG_WEN = 1'b1; S_AWADDR = a; S_WDATA = d; S_WSTRB = s;
      tick();
      S_REG_WEN = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      S_REG_RDEN = 1'b1; S_ARADDR = a;
      tick();
      S_REG_RDEN = 1'b0;
      d = S_RDATA;
   endtask

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_spie();
      logic [31:0] v;
      v        = '0;
      v[0]     = m_don;
      v[1]     = (mrxq.size() != 0);
      v[2]     = (mtxq.size() == 0);
      v[3]     = (mtxq.size() != DEPTH);
      v[4]     = m_rxovf;
      v[5]     = m_txovf;
      v[12:8]  = 5'(mrxq.size());
      v[20:16] = 5'(mtxq.size());
      return v;
   endfunction

   function automatic logic [7:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2) return 8'h10;
      if (r <= 5) return 8'h14;
      if (r == 6) return 8'h00;
      if (r == 7) return 8'h04;
      if (r == 8) return ($urandom_range(0, 1) == 0) ? 8'h08 : 8'h0C;
      return 8'($urandom_range(0, 255));
   endfunction

   // One clock of the model, from the inputs currently driven.
   task automatic model_step();
      logic [31:0] spie, new_mode;
      logic [7:0]  clr;
      logic        flush, txpush, txpop, txfull, rxpush, rxpop, rxfull;
      spie = m_spie();
      if (S_REG_RDEN) begin
         case (S_ARADDR)
            8'h00: m_rdata = m_spmode;
            8'h04: m_rdata = spie;
            8'h08: m_rdata = m_spim;
            8'h0C: m_rdata = m_spcom;
            8'h14: m_rdata = (mrxq.size() != 0) ? mrxq[0] : 32'h0;
            default: m_rdata = 32'h0;
         endcase
      end
      m_irq    = |(spie[5:0] & m_spim[5:0]);
      m_cmd    = S_REG_WEN && S_AWADDR == 8'h0C;
      new_mode = (S_REG_WEN && S_AWADDR == 8'h00) ? bmerge(m_spmode, S_WDATA, S_WSTRB) : m_spmode;
      flush    = m_spmode[31] && !new_mode[31];
      clr      = (S_REG_WEN && S_AWADDR == 8'h04 && S_WSTRB[0]) ? S_WDATA[7:0] : 8'h0;
      m_don    = (m_don & ~clr[0]) | core_done;
      m_rxovf  = m_rxovf & ~clr[4];
      m_txovf  = m_txovf & ~clr[5];
      txpush = S_REG_WEN && S_AWADDR == 8'h10;
      txpop  = tx_ready && mtxq.size() != 0;
      txfull = mtxq.size() == DEPTH;
      rxpush = rx_valid;
      rxpop  = S_REG_RDEN && S_ARADDR == 8'h14 && mrxq.size() != 0;
      rxfull = mrxq.size() == DEPTH;
      if (flush) begin
         mtxq.delete();
         mrxq.delete();
      end else begin
         if (txpush && txfull && !txpop) m_txovf = 1'b1;
         if (txpop) void'(mtxq.pop_front());
         if (txpush && !(txfull && !txpop)) mtxq.push_back(bmerge(32'h0, S_WDATA, S_WSTRB));
         if (rxpush && rxfull && !rxpop) m_rxovf = 1'b1;
         if (rxpop) void'(mrxq.pop_front());
         if (rxpush && !(rxfull && !rxpop)) mrxq.push_back(rx_data);
      end
      m_spmode = new_mode;
      if (S_REG_WEN && S_AWADDR == 8'h08) m_spim  = bmerge(m_spim,  S_WDATA, S_WSTRB);
      if (S_REG_WEN && S_AWADDR == 8'h0C) m_spcom = bmerge(m_spcom, S_WDATA, S_WSTRB);
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] txexp[4];

      vecs[0]  = '{1'b0, 8'h00, 32'h0,         4'h0, 8'h00, MODE_DEF};
      vecs[1]  = '{1'b0, 8'h00, 32'h0,         4'h0, 8'h04, 32'h0000_000C};
      vecs[2]  = '{1'b0, 8'h00, 32'h0,         4'h0, 8'h08, 32'h0};
      vecs[3]  = '{1'b0, 8'h00, 32'h0,         4'h0, 8'h0C, 32'h0};
      vecs[4]  = '{1'b0, 8'h00, 32'h0,         4'h0, 8'h10, 32'h0};
      vecs[5]  = '{1'b0, 8'h00, 32'h0,         4'h0, 8'h14, 32'h0};
      vecs[6]  = '{1'b0, 8'h00, 32'h0,         4'h0, 8'h3C, 32'h0};
      vecs[7]  = '{1'b1, 8'h00, 32'hFFFF_FFFF, 4'h1, 8'h00, 32'h8070_04FF};
      vecs[8]  = '{1'b1, 8'h08, 32'h1234_AB56, 4'h2, 8'h08, 32'h0000_AB00};
      vecs[9]  = '{1'b1, 8'h3C, 32'hFFFF_FFFF, 4'hF, 8'h3C, 32'h0};
      vecs[10] = '{1'b1, 8'h0C, 32'h1234_5678, 4'hC, 8'h0C, 32'h1234_0000};
      vecs[11] = '{1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, 8'h04, 32'h0000_000C};

      S_RESETN = 1'b0; S_REG_WEN = 1'b0; S_REG_RDEN = 1'b0; S_AWADDR = '0; S_ARADDR = '0;
      S_WDATA = '0; S_WSTRB = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; core_done = 1'b0;
      tick(); tick();
      check("rst_rdata", S_RDATA, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_cmd_start", 32'(cmd_start), 32'h0);
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_spmode", spmode, MODE_DEF);
      check("rst_spcom", spcom, 32'h0);
      S_RESETN = 1'b1;
      tick();

      // register map table
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr) wr(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
         rd(vecs[i].raddr, d);
         check($sformatf("vec%0d", i), d, vecs[i].exp);
      end

      // DON set by core_done, interrupt, W1C clear, set beating clear
      wr(8'h08, 32'h1, 4'hF);
      core_done = 1'b1; tick(); core_done = 1'b0;
      tick();
      check("irq_on_don", 32'(irq), 32'h1);
      rd(8'h04, d); check("spie_don", d, 32'h0000_000D);
      wr(8'h04, 32'h1, 4'hF);
      rd(8'h04, d); check("spie_don_clr", d, 32'h0000_000C);
      check("irq_after_clr", 32'(irq), 32'h0);
      core_done = 1'b1; wr(8'h04, 32'h1, 4'hF); core_done = 1'b0;
      rd(8'h04, d); check("set_beats_w1c", d, 32'h0000_000D);
      wr(8'h04, 32'h1, 4'hF);
      wr(8'h08, 32'h0, 4'hF);
      tick();
      check("irq_masked", 32'(irq), 32'h0);

      // TX fill, overflow, simultaneous push/pop at full, drain
      wr(8'h10, 32'h1111_2222, 4'b0101);
      wr(8'h10, 32'hCAFE_BABE, 4'hF);
      wr(8'h10, 32'hDEAD_BEEF, 4'hF);
      wr(8'h10, 32'h0123_4567, 4'hF);
      wr(8'h10, 32'h89AB_CDEF, 4'hF);
      check("tx_valid_full", 32'(tx_valid), 32'h1);
      check("tx_head_masked", tx_data, 32'h0011_0022);
      rd(8'h04, d); check("spie_tx_ovf", d, 32'h0004_0020);
      wr(8'h04, 32'h20, 4'h1);
      tx_ready = 1'b1; wr(8'h10, 32'h55AA_55AA, 4'hF); tx_ready = 1'b0;
      rd(8'h04, d); check("tx_pushpop_full", d, 32'h0004_0000);
      txexp[0] = 32'hCAFE_BABE; txexp[1] = 32'hDEAD_BEEF; txexp[2] = 32'h0123_4567; txexp[3] = 32'h55AA_55AA;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("tx_pop%0d", k), tx_data, txexp[k]);
         tx_ready = 1'b1; tick(); tx_ready = 1'b0;
      end
      rd(8'h04, d); check("spie_tx_empty", d, 32'h0000_000C);
      check("tx_valid_empty", 32'(tx_valid), 32'h0);

      // RX ordering, empty read, overflow, flush by clearing EN
      rx_valid = 1'b1; rx_data = 32'hA5A5_A5A5; tick();
      rx_data = 32'h5A5A_5A5A; tick(); rx_valid = 1'b0;
      rd(8'h04, d); check("spie_rx2", d, 32'h0000_020E);
      rd(8'h14, d); check("rx_rd0", d, 32'hA5A5_A5A5);
      rd(8'h14, d); check("rx_rd1", d, 32'h5A5A_5A5A);
      rd(8'h14, d); check("rx_rd_empty", d, 32'h0);
      rd(8'h04, d); check("spie_rx0", d, 32'h0000_000C);
      for (int k = 0; k < 5; k++) begin
         rx_valid = 1'b1; rx_data = 32'(k + 1); tick();
      end
      rx_valid = 1'b0;
      rd(8'h04, d); check("spie_rx_ovf", d, 32'h0000_041E);
      wr(8'h00, 32'h0, 4'b1000);
      rd(8'h04, d); check("spie_flush", d, 32'h0000_001C);
      wr(8'h04, 32'h10, 4'h1);
      wr(8'h00, 32'h8000_0000, 4'b1000);
      rd(8'h00, d); check("spmode_en_back", d, 32'h8070_04FF);

      // cmd_start pulse
      wr(8'h0C, 32'hA5, 4'hF);
      check("cmd_start_hi", 32'(cmd_start), 32'h1);
      tick();
      check("cmd_start_lo", 32'(cmd_start), 32'h0);

      // asynchronous reset in the middle of activity
      wr(8'h08, 32'h1, 4'hF);
      core_done = 1'b1; tick(); core_done = 1'b0;
      wr(8'h10, 32'h1, 4'hF);
      wr(8'h10, 32'h2, 4'hF);
      rd(8'h00, d);
      wr(8'h0C, 32'h77, 4'hF);
      check("pre_rst_cmd", 32'(cmd_start), 32'h1);
      check("pre_rst_irq", 32'(irq), 32'h1);
      check("pre_rst_txv", 32'(tx_valid), 32'h1);
      check("pre_rst_rdata", S_RDATA, 32'h8070_04FF);
      #2 S_RESETN = 1'b0;
      #1;
      check("arst_cmd", 32'(cmd_start), 32'h0);
      check("arst_irq", 32'(irq), 32'h0);
      check("arst_txv", 32'(tx_valid), 32'h0);
      check("arst_rdata", S_RDATA, 32'h0);
      check("arst_spmode", spmode, MODE_DEF);
      check("arst_spcom", spcom, 32'h0);
      #2 S_RESETN = 1'b1;
      tick();

      // randomized run against the queue model
      m_spmode = MODE_DEF; m_spim = '0; m_spcom = '0; m_rdata = '0;
      m_don = 1'b0; m_rxovf = 1'b0; m_txovf = 1'b0; m_irq = 1'b0; m_cmd = 1'b0;
      mtxq.delete(); mrxq.delete();
      for (int c = 0; c < 3000; c++) begin
         S_REG_WEN  = ($urandom_range(0, 2) == 0);
         S_AWADDR   = pick_addr();
         S_WDATA    = $urandom;
         if (S_AWADDR == 8'h00 && $urandom_range(0, 7) != 0) S_WDATA[31] = 1'b1;
         S_WSTRB    = 4'($urandom_range(0, 15));
         S_REG_RDEN = ($urandom_range(0, 2) == 0);
         S_ARADDR   = pick_addr();
         tx_ready   = ($urandom_range(0, 3) == 0);
         rx_valid   = ($urandom_range(0, 2) == 0);
         rx_data    = $urandom;
         core_done  = ($urandom_range(0, 15) == 0);
         model_step();
         tick();
         check("rnd_rdata", S_RDATA, m_rdata);
         check("rnd_irq", 32'(irq), 32'(m_irq));
         check("rnd_cmd", 32'(cmd_start), 32'(m_cmd));
         check("rnd_txv", 32'(tx_valid), 32'(mtxq.size() != 0));
         if (mtxq.size() != 0) check("rnd_txdata", tx_data, mtxq[0]);
         check("rnd_spmode", spmode, m_spmode);
         check("rnd_spcom", spcom, m_spcom);
      end
      S_REG_WEN = 1'b0; S_REG_RDEN = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; core_done = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
